stopwatch_frame_rx: RTL and testbench

STOPWATCH_FRAME_RX -- requirements
Module: stopwatch_frame_rx

---
 rtl/stopwatch_pkg.sv | 23 ++
 rtl/bin2bcd99.sv | 17 +
 rtl/stopwatch_frame_rx.sv | 163 ++++++++++++++++
 tb/tb_stopwatch_frame_rx.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch frame receiver:
// field limits, field count, FSM encoding and error codes.
package stopwatch_pkg;

   localparam int FIELDS = 5;

   typedef logic [6:0] field_t;

   // order: hs, sec, min, hr, dy
   localparam field_t LIMIT [FIELDS] = '{
      7'd100, 7'd60, 7'd60, 7'd24, 7'd100
   };

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COLLECT = 2'd1;
   localparam logic [1:0] S_CHECK   = 2'd2;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_RANGE   = 2'd1;
   localparam logic [1:0] ERR_ABORT   = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/bin2bcd99.sv
// Combinational 7-bit binary (0..99) to two-digit BCD,
// tens digit in the upper nibble.
module bin2bcd99 (
   input  logic [6:0] bin,
   output logic [7:0] bcd
);

   logic [3:0] tens;
   logic [3:0] ones;

   always_comb begin
      tens = 4'(bin / 7'd10);
      ones = 4'(bin % 7'd10);
      bcd  = {tens, ones};
   end

endmodule

// File: rtl/stopwatch_frame_rx.sv
// Receives five serial stopwatch fields per frame, range-checks
// them and publishes binary and BCD copies of each good frame.
module stopwatch_frame_rx
   import stopwatch_pkg::*;
#(
   parameter int TIMEOUT = 20000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_q,
   input  logic        slot_clk,
   input  logic [6:0]  din,
   output logic [6:0]  hs_o,
   output logic [6:0]  sec_o,
   output logic [6:0]  min_o,
   output logic [6:0]  hr_o,
   output logic [6:0]  dy_o,
   output logic [39:0] bcd_o,
   output logic        frame_valid,
   output logic        frame_err,
   output logic [1:0]  err_code,
   output logic [7:0]  err_cnt,
   output logic        busy
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);

   logic [2:0]    fq;
   logic [2:0]    sc;
   logic          fe;
   logic          se;
   logic [1:0]    state;
   logic [2:0]    idx;
   logic [TW-1:0] tcnt;
   field_t        fld [FIELDS];
   field_t        outf [FIELDS];
   logic [7:0]    bcd [FIELDS];
   logic          range_ok;
   logic [1:0]    err_kind;

   // [1:0] synchronize, [2] holds the previous level for edge detect
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fq <= 3'b111;
         sc <= 3'b000;
      end else begin
         fq <= {fq[1:0], frame_q};
         sc <= {sc[1:0], slot_clk};
      end
   end

   assign fe = fq[2] & ~fq[1];
   assign se = sc[1] & ~sc[2];

   for (genvar g = 0; g < FIELDS; g++) begin : g_bcd
      bin2bcd99 u_bcd (
         .bin (fld[g]),
         .bcd (bcd[g])
      );
   end

   always_comb begin
      range_ok = 1'b1;
      for (int i = 0; i < FIELDS; i++)
         if (fld[i] >= LIMIT[i])
            range_ok = 1'b0;
   end

   always_comb begin
      err_kind = ERR_NONE;
      case (state)
         S_COLLECT:
            if (fe) begin
               if (idx != 3'd0)
                  err_kind = ERR_ABORT;
            end else if (!se && tcnt == TO_MAX) begin
               err_kind = ERR_TIMEOUT;
            end
         S_CHECK:
            if (!range_ok)
               err_kind = ERR_RANGE;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         idx         <= 3'd0;
         tcnt        <= '0;
         bcd_o       <= '0;
         frame_valid <= 1'b0;
         for (int i = 0; i < FIELDS; i++) begin
            fld[i]  <= '0;
            outf[i] <= '0;
         end
      end else begin
         frame_valid <= 1'b0;
         case (state)
            S_IDLE:
               if (fe) begin
                  state <= S_COLLECT;
                  idx   <= 3'd0;
                  tcnt  <= '0;
               end
            S_COLLECT:
               if (fe) begin
                  idx  <= 3'd0;
                  tcnt <= '0;
               end else if (se) begin
                  fld[idx] <= din;
                  idx      <= idx + 3'd1;
                  tcnt     <= '0;
                  if (idx == 3'd4)
                     state <= S_CHECK;
               end else if (tcnt == TO_MAX) begin
                  state <= S_IDLE;
                  tcnt  <= '0;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            S_CHECK: begin
               if (range_ok) begin
                  for (int i = 0; i < FIELDS; i++)
                     outf[i] <= fld[i];
                  bcd_o       <= {bcd[4], bcd[3], bcd[2], bcd[1], bcd[0]};
                  frame_valid <= 1'b1;
               end
               // a frame start landing on the check cycle is not lost
               state <= fe ? S_COLLECT : S_IDLE;
               idx   <= 3'd0;
               tcnt  <= '0;
            end
            default:
               state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frame_err <= 1'b0;
         err_code  <= ERR_NONE;
         err_cnt   <= 8'd0;
      end else begin
         frame_err <= (err_kind != ERR_NONE);
         if (err_kind != ERR_NONE) begin
            err_code <= err_kind;
            if (err_cnt != 8'hff)
               err_cnt <= err_cnt + 8'd1;
         end
      end
   end

   assign hs_o  = outf[0];
   assign sec_o = outf[1];
   assign min_o = outf[2];
   assign hr_o  = outf[3];
   assign dy_o  = outf[4];
   assign busy  = (state == S_COLLECT) || (state == S_CHECK);

endmodule

// File: tb/tb_stopwatch_frame_rx.sv
// Directed bench for stopwatch_frame_rx: good, range, abort,
// timeout, simultaneous-edge, reset and saturation cases.
module tb_stopwatch_frame_rx;

   localparam int TO = 40;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        frame_q = 1'b1;
   logic        slot_clk = 1'b0;
   logic [6:0]  din = '0;
   logic [6:0]  hs_o, sec_o, min_o, hr_o, dy_o;
   logic [39:0] bcd_o;
   logic        frame_valid, frame_err, busy;
   logic [1:0]  err_code;
   logic [7:0]  err_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   int nvalid = 0;
   int nerr = 0;
   int v0, e0;
   bit seen;

   stopwatch_frame_rx #(.TIMEOUT(TO)) dut (
      .clk         (clk),
      .reset       (reset),
      .frame_q     (frame_q),
      .slot_clk    (slot_clk),
      .din         (din),
      .hs_o        (hs_o),
      .sec_o       (sec_o),
      .min_o       (min_o),
      .hr_o        (hr_o),
      .dy_o        (dy_o),
      .bcd_o       (bcd_o),
      .frame_valid (frame_valid),
      .frame_err   (frame_err),
      .err_code    (err_code),
      .err_cnt     (err_cnt),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_valid) nvalid++;
      if (frame_err)   nerr++;
   end

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic fstart();
      @(negedge clk);
      frame_q = 1'b0;
      wait_n(4);
      frame_q = 1'b1;
      wait_n(4);
   endtask

   // mode 0: no latency check; 1: expect frame_valid; 2: expect frame_err
   task automatic slot(input logic [6:0] d, input int mode);
      @(negedge clk);
      din = d;
      slot_clk = 1'b1;
      if (mode != 0) begin
         for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("lat_v%0d", k), frame_valid,
                (k == 4 && mode == 1));
            chk($sformatf("lat_e%0d", k), frame_err,
                (k == 4 && mode == 2));
         end
      end else begin
         wait_n(4);
      end
      slot_clk = 1'b0;
      wait_n(4);
   endtask

   task automatic frame(input logic [6:0] a, input logic [6:0] b,
                        input logic [6:0] c, input logic [6:0] d,
                        input logic [6:0] e, input int mode);
      fstart();
      slot(a, 0);
      slot(b, 0);
      slot(c, 0);
      slot(d, 0);
      slot(e, mode);
   endtask

   initial begin
      wait_n(3);
      chk("rst_busy", busy, 0);
      chk("rst_bcd", bcd_o, 0);
      chk("rst_cnt", err_cnt, 0);
      reset = 1'b1;
      wait_n(3);
      chk("rst_hs", hs_o, 0);
      chk("rst_code", err_code, 0);
      chk("rst_fv", frame_valid, 0);

      // good frame, then a stray sixth slot
      frame(7'd42, 7'd17, 7'd5, 7'd13, 7'd3, 1);
      chk("good_hs", hs_o, 42);
      chk("good_sec", sec_o, 17);
      chk("good_min", min_o, 5);
      chk("good_hr", hr_o, 13);
      chk("good_dy", dy_o, 3);
      chk("good_bcd", bcd_o, 40'h0313051742);
      chk("good_nv", nvalid, 1);
      slot(7'd9, 0);
      wait_n(4);
      chk("extra_nv", nvalid, 1);
      chk("extra_ne", nerr, 0);
      chk("extra_busy", busy, 0);

      // range error on sec
      frame(7'd10, 7'd60, 7'd1, 7'd1, 7'd1, 2);
      chk("rng_code", err_code, 1);
      chk("rng_cnt", err_cnt, 1);
      chk("rng_hs", hs_o, 42);
      chk("rng_bcd", bcd_o, 40'h0313051742);
      chk("rng_nv", nvalid, 1);

      // abort after three slots
      fstart();
      slot(7'd1, 0);
      slot(7'd2, 0);
      slot(7'd3, 0);
      frame(7'd99, 7'd59, 7'd59, 7'd23, 7'd99, 1);
      chk("abt_code", err_code, 2);
      chk("abt_cnt", err_cnt, 2);
      chk("abt_ne", nerr, 2);
      chk("abt_nv", nvalid, 2);
      chk("abt_bcd", bcd_o, 40'h9923595999);
      chk("abt_hr", hr_o, 23);

      // timeout after two slots
      fstart();
      slot(7'd4, 0);
      slot(7'd5, 0);
      chk("to_busy1", busy, 1);
      e0 = nerr;
      seen = 0;
      for (int k = 0; k < 200 && !seen; k++) begin
         @(negedge clk);
         if (nerr != e0) seen = 1;
      end
      chk("to_seen", seen, 1);
      chk("to_code", err_code, 3);
      chk("to_cnt", err_cnt, 3);
      chk("to_busy0", busy, 0);

      // fe while idx=0, with se in the same cycle
      fstart();
      @(negedge clk);
      din = 7'd77;
      frame_q = 1'b0;
      slot_clk = 1'b1;
      wait_n(4);
      frame_q = 1'b1;
      slot_clk = 1'b0;
      wait_n(4);
      slot(7'd1, 0);
      slot(7'd2, 0);
      slot(7'd3, 0);
      slot(7'd4, 0);
      slot(7'd5, 1);
      chk("sim_hs", hs_o, 1);
      chk("sim_bcd", bcd_o, 40'h0504030201);
      chk("sim_cnt", err_cnt, 3);

      // reset in the middle of a frame
      fstart();
      slot(7'd6, 0);
      slot(7'd6, 0);
      e0 = nerr;
      v0 = nvalid;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("mr_hs", hs_o, 0);
      chk("mr_bcd", bcd_o, 0);
      chk("mr_cnt", err_cnt, 0);
      chk("mr_code", err_code, 0);
      chk("mr_busy", busy, 0);
      wait_n(3);
      reset = 1'b1;
      wait_n(3);
      chk("mr_ne", nerr - e0, 0);
      frame(7'd7, 7'd8, 7'd9, 7'd10, 7'd11, 1);
      chk("mr_nv", nvalid - v0, 1);
      chk("mr_bcd2", bcd_o, 40'h1110090807);
      chk("mr_cnt2", err_cnt, 0);

      // saturation of the rejection counter
      e0 = nerr;
      for (int f = 0; f < 260; f++)
         frame(7'd100, 7'd0, 7'd0, 7'd0, 7'd0, 0);
      wait_n(4);
      chk("sat_cnt", err_cnt, 255);
      chk("sat_ne", nerr - e0, 260);
      chk("sat_code", err_code, 1);
      chk("sat_bcd", bcd_o, 40'h1110090807);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
